// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// sequencer states and requester port identifiers.
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin winner: on a tie the port that was not
// granted last time wins. Grant is one-hot, or zero when nobody requests.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/memory.sv
// 32x8 synchronous memory: writes and reads both act on the rising edge,
// with read data registered on the edge where rd is high.
module memory
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[addr] <= data_in;
        end
        if (rd) begin
            data_out_q <= mem_q[addr];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and three-cycle sequencer in front of the shared
// 32x8 memory; one command in flight at a time, one-cycle response pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic              req0_we,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              lat_we_q, lat_we_d;
    logic              lat_port_q, lat_port_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;

    logic [1:0]        grant;
    logic              handshake;
    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign handshake  = (state_q == IDLE) && (grant != 2'b00);
    assign req0_ready = (state_q == IDLE) && grant[0];
    assign req1_ready = (state_q == IDLE) && grant[1];
    assign winner     = grant[1] ? PORT_LS : PORT_IF;
    assign sel_we     = (winner == PORT_LS) ? req1_we    : req0_we;
    assign sel_addr   = (winner == PORT_LS) ? req1_addr  : req0_addr;
    assign sel_wdata  = (winner == PORT_LS) ? req1_wdata : req0_wdata;

    // The memory address/data registers double as the command latch, so they
    // only change on a handshake and hold through ACCESS, CAPTURE and IDLE.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        lat_we_d      = lat_we_q;
        lat_port_d    = lat_port_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_valid_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d       = ACCESS;
                    last_grant_d  = winner;
                    lat_we_d      = sel_we;
                    lat_port_d    = winner;
                    mem_rd_d      = !sel_we;
                    mem_wr_d      = sel_we;
                    mem_addr_d    = sel_addr;
                    mem_data_in_d = sel_wdata;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = IDLE;
                if (!lat_we_q) begin
                    rsp_rdata_d = mem_data_out;
                end
                rsp_valid_d[lat_port_q] = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= PORT_LS;
            lat_we_q      <= 1'b0;
            lat_port_q    <= PORT_IF;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            rsp_rdata_q   <= '0;
            rsp_valid_q   <= 2'b00;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            lat_we_q      <= lat_we_d;
            lat_port_q    <= lat_port_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter driving the real memory: a transaction table
// plus hand-written sequences for ties, alternation, reset and withdrawal.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic          req0_we, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic          busy, mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_we      (req0_we),
        .req1_we      (req1_we),
        .req0_addr    (req0_addr),
        .req1_addr    (req1_addr),
        .req0_wdata   (req0_wdata),
        .req1_wdata   (req1_wdata),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    memory #(.ADDR_W(AW), .DATA_W(DW)) u_memory (
        .clk      (clk),
        .rd       (mem_rd),
        .wr       (mem_wr),
        .addr     (mem_addr),
        .data_in  (mem_data_in),
        .data_out (mem_data_out)
    );

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expRdata;
    } vec_t;

    vec_t    vecs[8];
    int      passCount = 0;
    int      checkCount = 0;
    int      cycleCount = 0;
    int      rdWrClash = 0;
    int      grantPort[$];
    int      grantCycle[$];
    logic [DW-1:0] expHeldRdata = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Handshake log and read/write exclusivity watch, sampled mid-cycle.
    always @(negedge clk) begin
        cycleCount++;
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                grantPort.push_back(0);
                grantCycle.push_back(cycleCount);
            end
            if (req1_valid && req1_ready) begin
                grantPort.push_back(1);
                grantCycle.push_back(cycleCount);
            end
            if (mem_rd && mem_wr) rdWrClash++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            req0_valid = valid; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = valid; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    // One isolated transaction from IDLE, checked cycle by cycle through T+3.
    task automatic runTxn(input vec_t v, input string tag);
        @(posedge clk); #1;
        applyStimulus(v.port, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        checkOutput({tag, " ready"}, (v.port == 0) ? req0_ready : req1_ready, 1);
        checkOutput({tag, " busy T"}, busy, 0);
        @(posedge clk); #1;
        applyStimulus(v.port, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput({tag, " mem_rd T+1"}, mem_rd, !v.we);
        checkOutput({tag, " mem_wr T+1"}, mem_wr, v.we);
        checkOutput({tag, " mem_addr T+1"}, mem_addr, v.addr);
        if (v.we) checkOutput({tag, " mem_data_in T+1"}, mem_data_in, v.wdata);
        checkOutput({tag, " busy T+1"}, busy, 1);
        @(negedge clk);
        checkOutput({tag, " rd|wr T+2"}, {mem_rd, mem_wr}, 0);
        checkOutput({tag, " rsp T+2"}, {rsp1_valid, rsp0_valid}, 0);
        checkOutput({tag, " mem_addr hold T+2"}, mem_addr, v.addr);
        @(negedge clk);
        checkOutput({tag, " rsp T+3"}, {rsp1_valid, rsp0_valid}, (v.port == 0) ? 2'b01 : 2'b10);
        if (!v.we) expHeldRdata = v.expRdata;
        checkOutput({tag, " rsp_rdata T+3"}, rsp_rdata, expHeldRdata);
        checkOutput({tag, " busy T+3"}, busy, 0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expHeldRdata = '0;
    endtask

    initial begin
        vecs[0] = '{0, 1'b1, 5'd3,  8'hAA, 8'h00};
        vecs[1] = '{1, 1'b0, 5'd3,  8'h00, 8'hAA};
        vecs[2] = '{1, 1'b1, 5'd31, 8'h5C, 8'h00};
        vecs[3] = '{0, 1'b1, 5'd0,  8'h11, 8'h00};
        vecs[4] = '{0, 1'b0, 5'd31, 8'h00, 8'h5C};
        vecs[5] = '{1, 1'b0, 5'd0,  8'h00, 8'h11};
        vecs[6] = '{0, 1'b1, 5'd17, 8'h42, 8'h00};
        vecs[7] = '{1, 1'b0, 5'd17, 8'h00, 8'h42};

        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset ready", {req1_ready, req0_ready}, 0);
        checkOutput("reset rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        checkOutput("reset rsp_rdata", rsp_rdata, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset mem_rd/wr", {mem_rd, mem_wr}, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset mem_data_in", mem_data_in, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table-driven transactions");
        for (int i = 0; i < 8; i++) runTxn(vecs[i], $sformatf("vec%0d", i));

        $display("[TB] tie from reset");
        pulseReset();
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b1, 5'd6, 8'hAB);
        applyStimulus(1, 1'b1, 1'b0, 5'd6, 8'h00);
        @(negedge clk);
        checkOutput("tie ready", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("tie wait ACCESS ready1", req1_ready, 0);
        checkOutput("tie write mem_wr", mem_wr, 1);
        @(negedge clk);
        checkOutput("tie wait CAPTURE ready1", req1_ready, 0);
        @(negedge clk);
        checkOutput("tie rsp0 with grant1", {rsp1_valid, rsp0_valid, req1_ready}, 3'b011);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("tie read mem_rd", {mem_rd, mem_wr}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        checkOutput("tie rsp1", {rsp1_valid, rsp0_valid}, 2'b10);
        checkOutput("tie rdata", rsp_rdata, 8'hAB);

        $display("[TB] continuous contention");
        @(posedge clk); #1;
        grantPort.delete();
        grantCycle.delete();
        rdWrClash = 0;
        applyStimulus(0, 1'b1, 1'b0, 5'd3, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 5'd6, 8'h00);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (grantPort.size() >= 6) break;
        end
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        checkOutput("alt handshake count", grantPort.size(), 6);
        if (grantPort.size() >= 6) begin
            for (int i = 0; i < 6; i++)
                checkOutput($sformatf("alt grant%0d", i), grantPort[i], i % 2);
            for (int i = 1; i < 6; i++)
                checkOutput($sformatf("alt gap%0d", i), grantCycle[i] - grantCycle[i-1], 3);
        end
        repeat (3) @(posedge clk);
        checkOutput("alt rd&&wr never", rdWrClash, 0);

        $display("[TB] reset during write ACCESS");
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b1, 5'd3, 8'hFF);
        @(negedge clk);
        checkOutput("rstmid ready", req0_ready, 1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        checkOutput("rstmid mem_wr before", mem_wr, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstmid mem_rd/wr", {mem_rd, mem_wr}, 0);
        checkOutput("rstmid busy", busy, 0);
        checkOutput("rstmid mem_addr", mem_addr, 0);
        checkOutput("rstmid mem_data_in", mem_data_in, 0);
        checkOutput("rstmid rsp_rdata", rsp_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expHeldRdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rstmid no rsp c%0d", i), {rsp1_valid, rsp0_valid, busy}, 0);
        end
        runTxn('{1, 1'b0, 5'd3, 8'h00, 8'hAA}, "rstmid readback");

        $display("[TB] withdrawn request");
        @(posedge clk); #1;
        grantPort.delete();
        grantCycle.delete();
        applyStimulus(0, 1'b1, 1'b1, 5'd9, 8'h77);
        @(negedge clk);
        checkOutput("wd ready0", req0_ready, 1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b1, 1'b0, 5'd12, 8'h00);
        @(negedge clk);
        checkOutput("wd ready1 ACCESS", req1_ready, 0);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("wd rsp0", {rsp1_valid, rsp0_valid}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("wd idle c%0d", i), {mem_rd, mem_wr, busy, rsp1_valid}, 0);
        end
        checkOutput("wd handshakes", grantPort.size(), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the shared 32x8 synchronous `memory` block. It sits between two requesters (instruction-fetch side on port 0, load/store side on port 1) and the single `memory` instance. It accepts one command at a time through a valid/ready handshake and drives the `memory` `rd`/`wr`/`addr`/`data_in` pins for exactly one cycle. It returns a one-cycle response pulse carrying read data from `data_out`.

## Interface
- `ADDR_W`, 5, memory address width (32 locations)
- `DATA_W`, 8, memory data width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1  command present on port N
- `req0_ready`, `req1_ready`  out  1  command accepted this cycle (transfer = valid && ready)
- `req0_we`, `req1_we`  in  1  1 = write, 0 = read
- `req0_addr`, `req1_addr`  in  ADDR_W  target address
- `req0_wdata`, `req1_wdata`  in  DATA_W  write data
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle completion pulse for port N (reads and writes)
- `rsp_rdata`  out  DATA_W  read data, shared by both ports, qualified by `rspN_valid` of a read
- `busy`  out  1  high in ACCESS and CAPTURE
- `mem_rd`, `mem_wr`  out  1  to `memory` `rd`/`wr`
- `mem_addr`  out  ADDR_W  to `memory` `addr`
- `mem_data_in`  out  DATA_W  to `memory` `data_in`
- `mem_data_out`  in  DATA_W  from `memory` `data_out`; registered by `memory` on the edge where `rd`=1

## Operation
- FSM states:
  - IDLE: on handshake → ACCESS; otherwise stay.
  - ACCESS: always → CAPTURE.
  - CAPTURE: always → IDLE.
- IDLE, winner selection:
  - If only one `reqN_valid` is high, that port wins.
  - If both are high, the port that is not `last_grant` wins.
  - `reqN_ready` is high only in IDLE and only for the winner. It is combinational from the valids.
- On handshake:
  - Latch `we`, `addr`, `wdata` and the port ID.
  - Update `last_grant` to the winner.
- ACCESS:
  - Registered `mem_rd` = !we, `mem_wr` = we.
  - `mem_addr` and `mem_data_in` are taken from the latches.
  - `mem_rd` and `mem_wr` are never both 1.
- CAPTURE:
  - `mem_rd` and `mem_wr` = 0.
  - For a read, latch `mem_data_out` into `rsp_rdata`.
  - For a write, `rsp_rdata` holds its previous value.
- Response: `rspN_valid` pulses for the latched port in the cycle after CAPTURE. The FSM is in IDLE in that same cycle and may accept a new handshake.
- Holding rules:
  - Outside ACCESS, `mem_addr` and `mem_data_in` hold their last values.
  - A requester must hold valid and its fields stable until ready.
  - Dropping valid before ready withdraws the command with no side effect.
- Losing port: its request stays pending and wins the next IDLE handshake if still valid (starvation-free).

## Timing
- Handshake in cycle T:
  - `mem_rd`/`mem_wr` high in cycle T+1.
  - Memory acts on the edge ending T+1.
  - Data is latched at the end of T+2.
  - `rspN_valid` and `rsp_rdata` are valid in cycle T+3.
- Throughput: one access per 3 cycles; the next handshake is possible in T+3.
- Reset values:
  - State = IDLE, `last_grant` = 1 (port 0 wins the first tie).
  - All outputs 0: `req*_ready` (while valids are low), `rsp*_valid`, `rsp_rdata`, `busy`, `mem_rd`, `mem_wr`, `mem_addr`, `mem_data_in`.
- Reset asserted mid-transaction:
  - Everything clears immediately.
  - No response is issued.
  - If asserted during ACCESS before the clock edge, the memory write does not occur.
- Address wrap: none. `addr` 31 is a normal access; no incrementing.
- Simultaneous events:
  - A response pulse and a new handshake in the same cycle are both legal.
  - A new valid that arrives during ACCESS or CAPTURE waits; ready stays low.

## Structure
- Package `mem_arb_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults.
  - The state enum (IDLE, ACCESS, CAPTURE).
  - Port ID constants (`PORT_IF` = 0, `PORT_LS` = 1).
- Sub-module `rr_arb2` computes the combinational 2-way winner from `req[1:0]` and `last_grant` and outputs a one-hot grant. `mem_arbiter` owns the `last_grant` register, the FSM, the latches and the response logic.
- The bench instantiates `mem_arbiter` together with the real `memory`.

## Test plan
- Port 0 writes 0xAA to addr 3 (handshake at T); then port 1 reads addr 3 → `rsp0_valid` at T+3, and `rsp1_valid` with `rsp_rdata` = 0xAA 3 cycles after its handshake.
- Both ports valid from reset: port 0 writes 0xAB to addr 6, port 1 reads addr 6 → port 0 is granted first, port 1 next, and the read returns 0xAB.
- Both ports hold valid continuously for 6 accesses → grants alternate 0,1,0,1,0,1; `mem_rd`&&`mem_wr` is never seen; the gap between handshakes is exactly 3 cycles.
- Write 0x5C to addr 31 and read back; write 0x11 to addr 0 → readback is 0x5C and 0x11 respectively, with no aliasing.
- `rst_n` asserted low in the ACCESS cycle of a write of 0xFF to addr 3 (which previously held 0xAA) → outputs are 0 immediately, no `rsp*_valid`, and a later read of addr 3 returns 0xAA.
- Port 1 raises valid, then drops it while port 0 owns the bus → no `req1_ready` and no memory access for port 1.
